// File: rtl/pudp_frame_encoder_pkg.sv
// PUDP frame encoder shared types: FSM states, checksum modes,
// and the type-byte layout.
package pudp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TYPE,
      SEQ,
      DATA,
      CSUM,
      DROP
   } state_t;

   localparam int CSUM_XOR = 0;
   localparam int CSUM_SUM = 1;

   // Type byte is zero padding above the channel id.
   function automatic logic [7:0] type_byte(
      input logic [7:0]  id,
      input int unsigned id_w
   );
      logic [7:0] mask;
      mask = 8'hFF >> (8 - id_w);
      return id & mask;
   endfunction

endpackage

// File: rtl/pudp_frame_encoder_csum_acc.sv
// 8-bit frame checksum accumulator, XOR or modulo-256 sum.
module pudp_csum_acc
   import pudp_pkg::*;
#(
   parameter int CSUM_MODE = CSUM_XOR
) (
   input  logic       clki,
   input  logic       rsti,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] din,
   output logic [7:0] csum
);

   always_ff @(posedge clki) begin
      if (rsti || clr) begin
         csum <= '0;
      end else if (en) begin
         if (CSUM_MODE == CSUM_SUM) begin
            csum <= csum + din;
         end else begin
            csum <= csum ^ din;
         end
      end
   end

endmodule

// File: rtl/pudp_frame_encoder.sv
// PUDP frame encoder: type, per-channel sequence, payload, checksum.
// Oversize frames are truncated, marked by an inverted checksum.
module pudp_frame_encoder
   import pudp_pkg::*;
#(
   parameter int ID_W      = 2,
   parameter int CSUM_MODE = 0,
   parameter int MAX_LEN   = 1024,
   parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic            clki,
   input  logic            rsti,
   output logic            s_axis_tready,
   input  logic            s_axis_tvalid,
   input  logic            s_axis_tlast,
   input  logic [7:0]      s_axis_tdata,
   input  logic [ID_W-1:0] s_axis_tid,
   input  logic            m_axis_tready,
   output logic            m_axis_tvalid,
   output logic            m_axis_tlast,
   output logic [7:0]      m_axis_tdata,
   input  logic            seq_clr,
   output logic            frame_done,
   output logic            frame_err
);

   localparam int NUM_CH = 2 ** ID_W;

   state_t          fsm;
   logic [ID_W-1:0] tid_reg;
   logic [7:0]      seq_reg;
   logic [LEN_W-1:0] cnt;
   logic            err;
   logic [7:0]      seq [NUM_CH];

   logic [7:0]      csum;
   logic            m_hs;
   logic            s_hs;
   logic            len_hit;
   logic            acc_en;
   logic            acc_clr;

   assign m_hs    = m_axis_tvalid & m_axis_tready;
   assign s_hs    = s_axis_tvalid & s_axis_tready;
   assign len_hit = (cnt + LEN_W'(1)) == LEN_W'(MAX_LEN);

   assign acc_en  = m_hs & ((fsm == TYPE) |
                            (fsm == SEQ)  |
                            (fsm == DATA));
   assign acc_clr = m_hs & (fsm == CSUM);

   pudp_csum_acc #(
      .CSUM_MODE (CSUM_MODE)
   ) u_acc (
      .clki (clki),
      .rsti (rsti),
      .en   (acc_en),
      .clr  (acc_clr),
      .din  (m_axis_tdata),
      .csum (csum)
   );

   // Header and checksum come from registers; payload passes through.
   always_comb begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      unique case (fsm)
         TYPE: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = type_byte(8'(tid_reg), ID_W);
         end
         SEQ: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = seq_reg;
         end
         DATA: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
         end
         CSUM: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tdata  = err ? ~csum : csum;
         end
         DROP: begin
            s_axis_tready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clki) begin
      if (rsti) begin
         fsm        <= IDLE;
         tid_reg    <= '0;
         seq_reg    <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            seq[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         unique case (fsm)
            IDLE: begin
               if (s_axis_tvalid) begin
                  tid_reg <= s_axis_tid;
                  seq_reg <= seq[s_axis_tid];
                  fsm     <= TYPE;
               end
            end
            TYPE: begin
               if (m_hs) begin
                  fsm <= SEQ;
               end
            end
            SEQ: begin
               if (m_hs) begin
                  fsm <= DATA;
               end
            end
            DATA: begin
               if (m_hs) begin
                  cnt <= cnt + LEN_W'(1);
                  if (s_axis_tlast) begin
                     fsm <= CSUM;
                     err <= 1'b0;
                  end else if (len_hit) begin
                     fsm <= CSUM;
                     err <= 1'b1;
                  end
               end
            end
            CSUM: begin
               if (m_hs) begin
                  frame_done   <= 1'b1;
                  frame_err    <= err;
                  seq[tid_reg] <= seq[tid_reg] + 8'd1;
                  cnt          <= '0;
                  err          <= 1'b0;
                  fsm          <= err ? DROP : IDLE;
               end
            end
            DROP: begin
               if (s_hs && s_axis_tlast) begin
                  fsm <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
         // A clear in the same cycle as an increment wins.
         if (seq_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
               seq[i] <= '0;
            end
         end
      end
   end

endmodule
